// File: rtl/timing_nco_if.sv
// rtl/timing_nco_if.sv - sample/control/strobe bundle between the loop filter, timing NCO and interpolator
//
// Signals:
//   sample_val_i  one-cycle strobe per input sample (NCO advances only on it)
//   ctrl_i        signed loop-filter correction, qualified by ctrl_val_i
//   ctrl_val_i    one-cycle strobe loading ctrl_i into the NCO control register
//   strobe_o      one-cycle interpolation strobe
//   mu_o          fractional interval, updated with strobe_o and held between strobes
//   phase_o       0 = transition strobe, 1 = on-time strobe
//   sym_val_o     strobe_o AND phase_o
//   inc_sat_o     increment applied on the last sample was clamped
// Modports: master = loop side (drives sample/ctrl), slave = the NCO.
interface timing_nco_if #(
    parameter int WCTRL = 18,
    parameter int MU_W  = 16
);
    logic                    sample_val_i;
    logic signed [WCTRL-1:0] ctrl_i;
    logic                    ctrl_val_i;
    logic                    strobe_o;
    logic [MU_W-1:0]         mu_o;
    logic                    phase_o;
    logic                    sym_val_o;
    logic                    inc_sat_o;

    modport master (
        output sample_val_i, ctrl_i, ctrl_val_i,
        input  strobe_o, mu_o, phase_o, sym_val_o, inc_sat_o
    );

    modport slave (
        input  sample_val_i, ctrl_i, ctrl_val_i,
        output strobe_o, mu_o, phase_o, sym_val_o, inc_sat_o
    );
endinterface

// File: rtl/timing_nco.sv
// rtl/timing_nco.sv - interpolation-control NCO for MSK symbol-timing recovery
//
// Ports:
//   clk      clock
//   reset_n  synchronous active-low reset
//   nco      timing_nco_if.slave: sample_val_i/ctrl_i/ctrl_val_i in,
//            strobe_o/mu_o/phase_o/sym_val_o/inc_sat_o out (all outputs registered)
module timing_nco #(
    parameter int W_NCO    = 24,
    parameter int LOG2_INC = 23,
    parameter int WCTRL    = 18,
    parameter int CTRL_SHL = 6,
    parameter int MU_W     = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    timing_nco_if.slave  nco
);
    // Increment arithmetic is done two bits wider than the accumulator so the
    // shifted correction can never overflow before it is clamped.
    localparam int WI = W_NCO + 2;

    localparam logic signed [WI-1:0] NOM_INC = WI'(64'd1 << LOG2_INC);
    localparam logic signed [WI-1:0] INC_LO  = NOM_INC - (NOM_INC >>> 3);
    localparam logic signed [WI-1:0] INC_HI  = NOM_INC + (NOM_INC >>> 3);
    localparam logic [W_NCO-1:0]     INC_LO_W = W_NCO'(64'd7 << (LOG2_INC - 3));
    localparam logic [W_NCO-1:0]     INC_HI_W = W_NCO'(64'd9 << (LOG2_INC - 3));

    logic signed [WCTRL-1:0] ctrl_reg;
    logic [W_NCO-1:0]        acc;
    logic                    strobe;
    logic [MU_W-1:0]         mu;
    logic                    phase;
    logic                    sym_val;
    logic                    inc_sat;

    logic signed [WI-1:0]    ctrl_ext;
    logic signed [WI-1:0]    inc_raw;
    logic                    clamp_lo;
    logic                    clamp_hi;
    logic [W_NCO-1:0]        inc;
    logic [W_NCO:0]          sum;
    logic [W_NCO-1:0]        residual;
    logic                    wrap;
    logic [MU_W-1:0]         mu_next;

    always_comb begin
        ctrl_ext = {{(WI-WCTRL){ctrl_reg[WCTRL-1]}}, ctrl_reg};
        inc_raw  = NOM_INC + (ctrl_ext <<< CTRL_SHL);
        clamp_lo = (inc_raw < INC_LO);
        clamp_hi = (inc_raw > INC_HI);
        if (clamp_lo) begin
            inc = INC_LO_W;
        end else if (clamp_hi) begin
            inc = INC_HI_W;
        end else begin
            inc = inc_raw[W_NCO-1:0];
        end

        sum      = {1'b0, acc} + {1'b0, inc};
        residual = sum[W_NCO-1:0];
        wrap     = sum[W_NCO];

        // mu is the residual scaled to the nominal increment; a residual at or
        // above one nominal step cannot be represented and saturates.
        if (|residual[W_NCO-1:LOG2_INC]) begin
            mu_next = '1;
        end else begin
            mu_next = residual[LOG2_INC-1 -: MU_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_reg <= '0;
            acc      <= '0;
            strobe   <= 1'b0;
            mu       <= '0;
            phase    <= 1'b1;
            sym_val  <= 1'b0;
            inc_sat  <= 1'b0;
        end else begin
            // A sample in the same cycle as a ctrl load still sees the old ctrl_reg.
            if (nco.ctrl_val_i) begin
                ctrl_reg <= nco.ctrl_i;
            end

            strobe  <= 1'b0;
            sym_val <= 1'b0;

            if (nco.sample_val_i) begin
                acc     <= residual;
                inc_sat <= clamp_lo | clamp_hi;
                if (wrap) begin
                    strobe  <= 1'b1;
                    mu      <= mu_next;
                    phase   <= ~phase;
                    // The new phase is ~phase, so an on-time strobe is one where
                    // the previous phase was transition.
                    sym_val <= ~phase;
                end
            end
        end
    end

    assign nco.strobe_o  = strobe;
    assign nco.mu_o      = mu;
    assign nco.phase_o   = phase;
    assign nco.sym_val_o = sym_val;
    assign nco.inc_sat_o = inc_sat;
endmodule
